// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the fetch stage.
//
// Holds the fetch address and advances it by STEP each unstalled cycle.
// Exception and branch redirects are applied with fixed priority. A redirect
// that arrives during a stall is buffered and applied when the stall releases.
// A one-cycle BOOT state keeps instruction fetch disabled after reset.
//
// Optional feature macro: PC_UNIT_ALIGN_CHECK_EN
//   defined   : misaligned branch targets are force-aligned and flagged on addr_err
//   undefined : branch targets are used unmodified and addr_err is tied low
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   stall            hold PC this cycle
//   br_valid         branch/jump redirect request
//   br_target        branch/jump redirect address
//   exc_valid        exception redirect request (to EXC_VEC)
//   q                current fetch address (registered)
//   inst_ce          instruction memory enable
//   redirect_pending a buffered redirect is waiting for stall release
//   addr_err         one-cycle misaligned-branch pulse

module pc_unit #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = 32'h0000_0000,
    parameter int unsigned       STEP      = 4,
    parameter logic [WIDTH-1:0]  EXC_VEC   = 32'h0000_0380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] q,
    output logic             inst_ce,
    output logic             redirect_pending,
    output logic             addr_err
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t           state;
    logic             pend_valid;
    logic             pend_exc;    // pending entry is an exception; branches may not replace it
    logic [WIDTH-1:0] pend_addr;
    logic [WIDTH-1:0] br_eff;

`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam int unsigned     ALIGN_BITS = $clog2(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    logic br_misaligned;
    logic br_taken;

    assign br_eff        = br_target & ALIGN_MASK;
    assign br_misaligned = |(br_target & ~ALIGN_MASK);

    // The branch target is consumed (unstalled, nothing outranks it) or
    // captured (stalled, no exception this cycle or already pending).
    always_comb begin
        br_taken = 1'b0;
        if (state == RUN && br_valid && !exc_valid) begin
            if (!stall)
                br_taken = !pend_valid;
            else
                br_taken = !(pend_valid && pend_exc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            addr_err <= 1'b0;
        else
            addr_err <= br_taken && br_misaligned;
    end
`else
    assign br_eff   = br_target;
    assign addr_err = 1'b0;
`endif

    assign inst_ce          = (state == RUN) && !stall;
    assign redirect_pending = pend_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            q          <= RESET_VEC;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            pend_addr  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (exc_valid)
                            q <= EXC_VEC;
                        else if (pend_valid)
                            q <= pend_addr;
                        else if (br_valid)
                            q <= br_eff;
                        else
                            q <= q + WIDTH'(STEP);
                        pend_valid <= 1'b0;
                        pend_exc   <= 1'b0;
                    end else begin
                        if (exc_valid) begin
                            pend_addr  <= EXC_VEC;
                            pend_valid <= 1'b1;
                            pend_exc   <= 1'b1;
                        end else if (br_valid && !(pend_valid && pend_exc)) begin
                            pend_addr  <= br_eff;
                            pend_valid <= 1'b1;
                            pend_exc   <= 1'b0;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed self-checking bench for pc_unit (RESET_VEC = 32'h100).

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] q;
    logic        inst_ce;
    logic        redirect_pending;
    logic        addr_err;

    int n_assert;
    int n_fail;

    pc_unit #(
        .WIDTH    (32),
        .RESET_VEC(32'h0000_0100),
        .STEP     (4),
        .EXC_VEC  (32'h0000_0380)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .exc_valid       (exc_valid),
        .q               (q),
        .inst_ce         (inst_ce),
        .redirect_pending(redirect_pending),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] exp_q,
                             input logic exp_ce, input logic exp_pend);
        chk({tag, ".q"},    q,                       exp_q);
        chk({tag, ".ce"},   {31'b0, inst_ce},        {31'b0, exp_ce});
        chk({tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, exp_pend});
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        exc_valid = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        chk_state("rst_async", 32'h100, 1'b0, 1'b0);
        chk("rst_async.err", {31'b0, addr_err}, 32'h0);
        step;
        step;
        chk_state("rst_hold", 32'h100, 1'b0, 1'b0);

        // Release; the boot edge ignores a branch request
        rst       = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h700;
        step;
        br_valid  = 1'b0;
        chk_state("boot", 32'h100, 1'b1, 1'b0);
        step;
        chk_state("adv1", 32'h104, 1'b1, 1'b0);
        step;
        chk_state("adv2", 32'h108, 1'b1, 1'b0);

        // Plain branch to 0x200
        br_valid  = 1'b1;
        br_target = 32'h200;
        step;
        br_valid  = 1'b0;
        chk_state("br200", 32'h200, 1'b1, 1'b0);

        // Exception outranks a simultaneous branch
        exc_valid = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h400;
        step;
        exc_valid = 1'b0;
        br_target = 32'h200;
        chk("prio.q", q, 32'h380);
        step;
        br_valid  = 1'b0;
        chk("back200.q", q, 32'h200);

        // Stall buffering: branch in first stalled cycle, three stall cycles
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h500;
        #1;
        chk("stall.ce_comb", {31'b0, inst_ce}, 32'h0);
        step;
        br_valid  = 1'b0;
        chk_state("stall1", 32'h200, 1'b0, 1'b1);
        step;
        step;
        chk_state("stall3", 32'h200, 1'b0, 1'b1);
        stall = 1'b0;
        #1;
        chk("release.ce_comb", {31'b0, inst_ce}, 32'h1);
        step;
        chk_state("release", 32'h500, 1'b1, 1'b0);

        // Branch, exception, branch during one stall: exception sticks
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h500;
        step;
        br_valid  = 1'b0;
        exc_valid = 1'b1;
        step;
        exc_valid = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h600;
        step;
        br_valid  = 1'b0;
        chk_state("ow1.hold", 32'h500, 1'b0, 1'b1);
        stall = 1'b0;
        step;
        chk_state("ow1.rel", 32'h380, 1'b1, 1'b0);

        // Branch then newer branch: newer wins
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h500;
        step;
        br_target = 32'h600;
        step;
        br_valid  = 1'b0;
        stall     = 1'b0;
        step;
        chk_state("ow2.rel", 32'h600, 1'b1, 1'b0);

        // Fresh branch at release edge loses to the pending entry
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h700;
        step;
        stall     = 1'b0;
        br_target = 32'h800;
        step;
        chk("fresh_loses.q", q, 32'h700);
        step;
        br_valid  = 1'b0;
        chk("fresh_next.q", q, 32'h800);

        // Exception at release edge beats the pending branch
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h900;
        step;
        br_valid  = 1'b0;
        stall     = 1'b0;
        exc_valid = 1'b1;
        step;
        exc_valid = 1'b0;
        chk_state("exc_rel", 32'h380, 1'b1, 1'b0);

        // Asynchronous reset mid-stall with a pending redirect
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h500;
        step;
        br_valid  = 1'b0;
        chk("pre_rst.pend", {31'b0, redirect_pending}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk_state("rst_mid", 32'h100, 1'b0, 1'b0);
        stall = 1'b0;
        #1 rst = 1'b1;
        step;
        chk_state("reboot", 32'h100, 1'b1, 1'b0);
        step;
        chk("reboot_adv.q", q, 32'h104);

        // Wrap at the top of the address space
        br_valid  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        step;
        br_valid  = 1'b0;
        chk("top.q", q, 32'hFFFF_FFFC);
        step;
        chk("wrap.q", q, 32'h0);
        step;
        chk("wrap_adv.q", q, 32'h4);

        // Misaligned branch target
        br_valid  = 1'b1;
        br_target = 32'h503;
        step;
        br_valid  = 1'b0;
`ifdef PC_UNIT_ALIGN_CHECK_EN
        chk("align.q", q, 32'h500);
        chk("align.err", {31'b0, addr_err}, 32'h1);
`else
        chk("align.q", q, 32'h503);
        chk("align.err", {31'b0, addr_err}, 32'h0);
`endif
        step;
        chk("align_after.err", {31'b0, addr_err}, 32'h0);

        // Exception redirect is never flagged
        exc_valid = 1'b1;
        step;
        exc_valid = 1'b0;
        chk("exc_noerr.q", q, 32'h380);
        chk("exc_noerr.err", {31'b0, addr_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
